// File: rtl/fb_burst_seq.sv
// fb_burst_seq: burst sequencer behind the 2-client round-robin arbiter.
// Latches the granted client's descriptor, issues one memory beat per
// accepted cycle, routes read returns back to the owner, pulses done, then
// holds until the owner drops its request so the arbiter can rotate.
// Optional build macro FB_SEQ_STATS_EN adds per-client beat counters and a
// stall counter (saturating, 32 bit).
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for a grant that matches a live request
// S_LOAD  | descriptor latched, one cycle before the first command
// S_BURST | mem_valid high, one beat per handshake
// S_DRAIN | read burst fully issued, waiting for outstanding returns
// S_DONE  | one-cycle done pulse to the owner
// S_HOLD  | waiting for the owner to drop its request
module fb_burst_seq #(
  parameter int AW = 20,
  parameter int DW = 16,
  parameter int LW = 8
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic [1:0]    i_request,
  input  logic [1:0]    i_grant,
  input  logic [AW-1:0] i_req_addr0,
  input  logic [AW-1:0] i_req_addr1,
  input  logic [LW-1:0] i_req_len0,
  input  logic [LW-1:0] i_req_len1,
  input  logic          i_req_we0,
  input  logic          i_req_we1,
  input  logic [DW-1:0] i_wr_data0,
  input  logic [DW-1:0] i_wr_data1,
  output logic [1:0]    o_wr_ack,
  output logic [DW-1:0] o_rd_data,
  output logic [1:0]    o_rd_valid,
  output logic [1:0]    o_done,
  output logic          o_mem_valid,
  input  logic          i_mem_ready,
  output logic [AW-1:0] o_mem_addr,
  output logic          o_mem_we,
  output logic [DW-1:0] o_mem_wdata,
  input  logic          i_mem_rvalid,
  input  logic [DW-1:0] i_mem_rdata
`ifdef FB_SEQ_STATS_EN
  ,
  output logic [31:0]   o_stat_beats0,
  output logic [31:0]   o_stat_beats1,
  output logic [31:0]   o_stat_stall
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_BURST, S_DRAIN, S_DONE, S_HOLD
  } state_t;

  localparam logic [LW-1:0] ONE = LW'(1);

  state_t        r_state, w_next;
  logic          r_owner;
  logic [AW-1:0] r_addr;
  logic [LW-1:0] r_len;
  logic [LW-1:0] r_beat;
  logic [LW-1:0] r_outst;
  logic          r_we;

  logic [1:0]    w_gnt;
  logic [1:0]    w_own_oh;
  logic [LW-1:0] w_sel_len;
  logic          w_hs;
  logic          w_rd_issue;
  logic          w_ret;
  logic          w_last;

  assign w_gnt      = i_grant & i_request;
  assign w_own_oh   = r_owner ? 2'b10 : 2'b01;
  assign w_sel_len  = w_gnt[0] ? i_req_len0 : i_req_len1;
  assign w_hs       = (r_state == S_BURST) && i_mem_ready;
  assign w_rd_issue = w_hs && !r_we;
  // Returns only count while a read is outstanding; stray ones (e.g. after
  // a reset abort) are dropped here.
  assign w_ret      = i_mem_rvalid && (r_outst != '0);
  assign w_last     = (r_beat == r_len - ONE);

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_reset) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_gnt != 2'b00) w_next = S_LOAD;
      S_LOAD:  w_next = S_BURST;
      S_BURST: if (w_hs && w_last) w_next = r_we ? S_DONE : S_DRAIN;
      S_DRAIN: if (r_outst == '0) w_next = S_DONE;
      S_DONE:  w_next = S_HOLD;
      S_HOLD:  if (!i_request[r_owner]) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs; command fields are gated to zero outside BURST.
  always_comb begin
    o_mem_valid = 1'b0;
    o_mem_addr  = '0;
    o_mem_we    = 1'b0;
    o_mem_wdata = '0;
    o_wr_ack    = 2'b00;
    o_rd_valid  = 2'b00;
    o_rd_data   = '0;
    o_done      = 2'b00;
    if (r_state == S_BURST) begin
      o_mem_valid = 1'b1;
      o_mem_addr  = r_addr + AW'(r_beat);
      o_mem_we    = r_we;
      if (r_we) o_mem_wdata = r_owner ? i_wr_data1 : i_wr_data0;
    end
    if (w_hs && r_we) o_wr_ack = w_own_oh;
    if (w_ret) begin
      o_rd_valid = w_own_oh;
      o_rd_data  = i_mem_rdata;
    end
    if (r_state == S_DONE) o_done = w_own_oh;
  end

  // Descriptor latch, beat counter and outstanding-read counter.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_owner <= 1'b0;
      r_addr  <= '0;
      r_len   <= '0;
      r_we    <= 1'b0;
      r_beat  <= '0;
      r_outst <= '0;
    end else begin
      if (r_state == S_IDLE && w_gnt != 2'b00) begin
        r_owner <= ~w_gnt[0];
        r_addr  <= w_gnt[0] ? i_req_addr0 : i_req_addr1;
        r_len   <= (w_sel_len == '0) ? ONE : w_sel_len;
        r_we    <= w_gnt[0] ? i_req_we0 : i_req_we1;
        r_beat  <= '0;
      end
      if (w_hs) r_beat <= r_beat + ONE;
      case ({w_rd_issue, w_ret})
        2'b10:   r_outst <= r_outst + ONE;
        2'b01:   r_outst <= r_outst - ONE;
        default: r_outst <= r_outst;
      endcase
    end
  end

`ifndef SYNTHESIS
  // Flag memory returns that arrive with nothing outstanding.
  always_ff @(posedge i_clk) begin
    if (i_reset && i_mem_rvalid && r_outst == '0)
      $display("fb_burst_seq: unexpected mem_rvalid ignored, no read outstanding (t=%0t)", $time);
  end
`endif

`ifdef FB_SEQ_STATS_EN
  logic [31:0] r_stat_beats0, r_stat_beats1, r_stat_stall;

  // Saturating activity counters.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_stat_beats0 <= '0;
      r_stat_beats1 <= '0;
      r_stat_stall  <= '0;
    end else begin
      if (w_hs && !r_owner && r_stat_beats0 != '1) r_stat_beats0 <= r_stat_beats0 + 32'd1;
      if (w_hs &&  r_owner && r_stat_beats1 != '1) r_stat_beats1 <= r_stat_beats1 + 32'd1;
      if (r_state == S_BURST && !i_mem_ready && r_stat_stall != '1)
        r_stat_stall <= r_stat_stall + 32'd1;
    end
  end

  assign o_stat_beats0 = r_stat_beats0;
  assign o_stat_beats1 = r_stat_beats1;
  assign o_stat_stall  = r_stat_stall;
`endif

endmodule

// File: tb/tb_fb_burst_seq.sv
// Directed bench for fb_burst_seq: reset, write/read bursts, round-robin
// alternation, address wrap, zero length and reset abort mid-read.
module tb_fb_burst_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  request, grant;
  logic [19:0] req_addr0, req_addr1;
  logic [7:0]  req_len0, req_len1;
  logic        req_we0, req_we1;
  logic [15:0] wr_data0, wr_data1;
  logic [1:0]  wr_ack, rd_valid, done;
  logic [15:0] rd_data;
  logic        mem_valid, mem_ready, mem_we, mem_rvalid;
  logic [19:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
`ifdef FB_SEQ_STATS_EN
  logic [31:0] stat_beats0, stat_beats1, stat_stall;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [63:0] outvec;
  assign outvec = {4'b0, wr_ack, rd_data, rd_valid, done, mem_valid, mem_addr, mem_we, mem_wdata};

  fb_burst_seq dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_request    (request),
    .i_grant      (grant),
    .i_req_addr0  (req_addr0),
    .i_req_addr1  (req_addr1),
    .i_req_len0   (req_len0),
    .i_req_len1   (req_len1),
    .i_req_we0    (req_we0),
    .i_req_we1    (req_we1),
    .i_wr_data0   (wr_data0),
    .i_wr_data1   (wr_data1),
    .o_wr_ack     (wr_ack),
    .o_rd_data    (rd_data),
    .o_rd_valid   (rd_valid),
    .o_done       (done),
    .o_mem_valid  (mem_valid),
    .i_mem_ready  (mem_ready),
    .o_mem_addr   (mem_addr),
    .o_mem_we     (mem_we),
    .o_mem_wdata  (mem_wdata),
    .i_mem_rvalid (mem_rvalid),
    .i_mem_rdata  (mem_rdata)
`ifdef FB_SEQ_STATS_EN
    ,
    .o_stat_beats0(stat_beats0),
    .o_stat_beats1(stat_beats1),
    .o_stat_stall (stat_stall)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Single write burst with mem_ready held high, checked beat by beat.
  task automatic run_write(input int c, input logic [19:0] a, input logic [7:0] l,
                           input int nbeats, input string tag);
    logic [1:0]  oh;
    logic [19:0] ea;
    oh = (c == 0) ? 2'b01 : 2'b10;
    step();
    if (c == 0) begin req_addr0 = a; req_len0 = l; req_we0 = 1'b1; end
    else        begin req_addr1 = a; req_len1 = l; req_we1 = 1'b1; end
    request = oh; grant = oh; mem_ready = 1'b1;
    @(negedge clk);
    check({tag, "_idle_mv"}, mem_valid, 0);
    step();
    grant = 2'b00;
    @(negedge clk);
    check({tag, "_load_mv"}, mem_valid, 0);
    for (int k = 0; k < nbeats; k++) begin
      step();
      if (c == 0) wr_data0 = 16'hA000 + 16'(k);
      else        wr_data1 = 16'hA000 + 16'(k);
      @(negedge clk);
      ea = a + 20'(k);
      check({tag, "_mv"},    mem_valid, 1);
      check({tag, "_addr"},  mem_addr, ea);
      check({tag, "_we"},    mem_we, 1);
      check({tag, "_wack"},  wr_ack, oh);
      check({tag, "_wdata"}, mem_wdata, 16'hA000 + 16'(k));
    end
    step();
    @(negedge clk);
    check({tag, "_done"},      done, oh);
    check({tag, "_done_mv"},   mem_valid, 0);
    step();
    @(negedge clk);
    check({tag, "_done_once"}, done, 2'b00);
    step();
    request = 2'b00;
    @(negedge clk);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] rdy_v, rv_v, mv_v, dn_v;
    int          beat_t [12];
    logic [19:0] ra;
    int          acks[$], dones[$], done_cyc[$], first_hs[$];
    int          ndone, drop, ovl, own;
    bit          prev_ack, saw;

    reset = 1'b0; request = 2'b00; grant = 2'b00;
    req_addr0 = '0; req_addr1 = '0; req_len0 = '0; req_len1 = '0;
    req_we0 = 1'b0; req_we1 = 1'b0; wr_data0 = '0; wr_data1 = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    // Reset held low for two clocks, then idle with no request.
    repeat (2) begin
      step();
      @(negedge clk);
      check("rst_outputs", outvec, 64'h0);
    end
    step();
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_outputs", outvec, 64'h0);
    repeat (3) begin
      step();
      @(negedge clk);
      check("idle_no_req_mv", mem_valid, 0);
    end
    // Grant with its request low is ignored.
    grant = 2'b01;
    repeat (4) begin
      step();
      @(negedge clk);
      check("gnt_no_req_out", outvec, 64'h0);
    end
    grant = 2'b00;

    // Write, client 0, len 4 at 0x100.
    run_write(0, 20'h00100, 8'd4, 4, "wr0");

    // Read, client 1, len 3, ready toggling, read latency 2.
    ra        = 20'h20040;
    req_addr1 = ra; req_len1 = 8'd3; req_we1 = 1'b0;
    rdy_v  = 12'b0000_0101_0100;
    rv_v   = 12'b0001_0101_0000;
    mv_v   = 12'b0000_0111_1100;
    dn_v   = 12'b0100_0000_0000;
    beat_t = '{0, 0, 0, 1, 1, 2, 2, 0, 0, 0, 0, 0};
    for (int k = 0; k < 12; k++) begin
      step();
      if (k == 0) begin request = 2'b10; grant = 2'b10; end
      if (k == 1) grant = 2'b00;
      mem_ready  = rdy_v[k];
      mem_rvalid = rv_v[k];
      mem_rdata  = 16'hB000 + 16'(k);
      @(negedge clk);
      check("rd1_mv", mem_valid, mv_v[k]);
      if (mv_v[k]) check("rd1_addr", mem_addr, ra + 20'(beat_t[k]));
      check("rd1_we", mem_we, 0);
      check("rd1_wack", wr_ack, 2'b00);
      check("rd1_rvalid", rd_valid, {rv_v[k], 1'b0});
      if (rv_v[k]) check("rd1_rdata", rd_data, 16'hB000 + 16'(k));
      check("rd1_done", done, {dn_v[k], 1'b0});
    end
    step();
    request = 2'b00; mem_ready = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
    step();

    // Both clients requesting, write len 2 each; bench acts as arbiter.
    step();
    req_addr0 = 20'h00300; req_addr1 = 20'h00400;
    req_len0 = 8'd2; req_len1 = 8'd2; req_we0 = 1'b1; req_we1 = 1'b1;
    wr_data0 = 16'h1111; wr_data1 = 16'h2222;
    request = 2'b11; grant = 2'b01; mem_ready = 1'b1;
    ndone = 0; drop = -1; ovl = 0; prev_ack = 1'b0; own = 0;
    for (int t = 0; t < 60 && ndone < 4; t++) begin
      @(negedge clk);
      saw = 1'b0;
      if (wr_ack == 2'b01)      acks.push_back(0);
      else if (wr_ack == 2'b10) acks.push_back(1);
      else if (wr_ack == 2'b11) ovl++;
      if (wr_ack != 2'b00 && !prev_ack) first_hs.push_back(cyc);
      prev_ack = (wr_ack != 2'b00);
      if (done != 2'b00 && mem_valid) ovl++;
      if (done == 2'b11) ovl++;
      if (done != 2'b00) begin
        own = (done == 2'b10) ? 1 : 0;
        dones.push_back(own);
        done_cyc.push_back(cyc);
        ndone++;
        saw = 1'b1;
      end
      step();
      if (drop >= 0) begin request[drop] = 1'b1; drop = -1; end
      if (saw) begin
        request[own] = 1'b0;
        drop  = own;
        grant = (own == 0) ? 2'b10 : 2'b01;
      end
    end
    check("rr_ndone", ndone, 4);
    check("rr_overlap", ovl, 0);
    check("rr_nacks", acks.size(), 8);
    for (int i = 0; i < acks.size(); i++) check("rr_ack_owner", acks[i], (i / 2) % 2);
    for (int i = 0; i < dones.size(); i++) check("rr_done_owner", dones[i], i % 2);
    for (int r = 1; r < first_hs.size() && r < done_cyc.size() + 1; r++)
      check("rr_done_to_next_cmd", first_hs[r] - done_cyc[r-1], 4);
    request = 2'b00; grant = 2'b00;
    step();
    step();

    // Address wrap and zero length.
    run_write(0, 20'hFFFFE, 8'd3, 3, "wrap");
    run_write(1, 20'h12345, 8'd0, 1, "len0");

    // Reset during DRAIN with two reads outstanding.
    step();
    req_addr0 = 20'h05000; req_len0 = 8'd2; req_we0 = 1'b0;
    request = 2'b01; grant = 2'b01; mem_ready = 1'b1; mem_rvalid = 1'b0;
    @(negedge clk);
    step();
    grant = 2'b00;
    @(negedge clk);
    step();
    @(negedge clk);
    check("rst_rd_addr0", mem_addr, 20'h05000);
    step();
    @(negedge clk);
    check("rst_rd_addr1", mem_addr, 20'h05001);
    step();
    @(negedge clk);
    check("rst_rd_drain_mv", mem_valid, 0);
    check("rst_rd_drain_done", done, 2'b00);
    reset = 1'b0;
    step();
    request = 2'b00; mem_rvalid = 1'b1; mem_rdata = 16'hDEAD;
    @(negedge clk);
    check("rst_rd_in_reset", outvec, 64'h0);
    step();
    reset = 1'b1; mem_rvalid = 1'b1; mem_rdata = 16'hBEEF;
    @(negedge clk);
    check("rst_rd_late_rvalid", rd_valid, 2'b00);
    check("rst_rd_no_done", done, 2'b00);
    step();
    mem_rvalid = 1'b0;
    @(negedge clk);
    check("rst_rd_quiet", outvec, 64'h0);
    // Back in IDLE: a fresh burst starts with the normal 2-cycle latency.
    run_write(1, 20'h00777, 8'd1, 1, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
